// File: rtl/disp_scan_cntrl.sv
// -----------------------------------------------------------------------------
// disp_scan_cntrl
//   Self-scanning N-digit 7-segment display driver. A prescaler divides
//   clk_10Mhz into digit slots and the anode scan steps through the digits on
//   each slot boundary. Digit data, enables and brightness are written into a
//   shadow buffer with 'load'. The shadow is copied into the active buffer only
//   when the scan wraps from the last digit to digit 0, so a frame never mixes
//   old and new data. Inside each slot the anode stays off for GUARD cycles to
//   suppress ghosting. After that the digit is lit for a duty set by the
//   brightness code.
//
// Ports
//   clk_10Mhz    in   1             system clock
//   reset        in   1             asynchronous active-low reset
//   seg_data     in   8*NUM_DIGITS  digit d pattern at [8d+7:8d], active-low,
//                                   bit7 = DP, bit0 = segment a
//   digit_en     in   NUM_DIGITS    1 = digit displayed, 0 = blanked
//   brightness   in   BRIGHT_W      0 = dimmest non-zero duty, all-ones = full
//   load         in   1             strobe: capture inputs into the shadow buffer
//   seg          out  8             active-low segment drive (registered)
//   an           out  NUM_DIGITS    active-low anode drive, one-cold (registered)
//   frame_start  out  1             pulse on the cycle after the scan wraps
//
// The reset deassertion must already be synchronised to clk_10Mhz upstream.
// -----------------------------------------------------------------------------
module disp_scan_cntrl #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 10_000_000,
  parameter int SCAN_HZ    = 1_000,
  parameter int BRIGHT_W   = 4,
  parameter int GUARD      = 2
) (
  input  logic                    clk_10Mhz,
  input  logic                    reset,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int OW  = CW + BRIGHT_W + 1;

  // Parameter sanity checks.
  if (DIV < 2**BRIGHT_W) begin : g_bad_div
    $error("disp_scan_cntrl: DIV (%0d) smaller than 2**BRIGHT_W", DIV);
  end
  if (GUARD >= DIV) begin : g_bad_guard
    $error("disp_scan_cntrl: GUARD (%0d) must be below DIV (%0d)", GUARD, DIV);
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("disp_scan_cntrl: NUM_DIGITS (%0d) out of range 1..16", NUM_DIGITS);
  end

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [8*NUM_DIGITS-1:0] sh_seg, ac_seg;
  logic [NUM_DIGITS-1:0]   sh_en,  ac_en;
  logic [BRIGHT_W-1:0]     sh_br,  ac_br;
  logic                    pending;

  logic                    tick;
  logic                    wrap;
  logic [OW-1:0]           on_cyc;
  logic [OW-1:0]           lit_end;
  logic [OW-1:0]           cnt_ext;
  logic                    lit;
  logic [7:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  assign tick = (cnt == CW'(DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  always_comb begin
    on_cyc  = ((OW'(ac_br) + OW'(1)) * OW'(DIV)) >> BRIGHT_W;
    // At the lowest codes on_cyc can fall inside the guard window. Keep at
    // least one lit cycle so that code 0 is still visible.
    lit_end = (on_cyc > OW'(GUARD)) ? on_cyc : OW'(GUARD + 1);
    cnt_ext = OW'(cnt);
    lit     = (cnt_ext >= OW'(GUARD)) && (cnt_ext < lit_end) && ac_en[idx];
    seg_nxt = 8'hFF;
    an_nxt  = '1;
    if (lit) begin
      seg_nxt = ac_seg[8*int'(idx) +: 8];
      an_nxt  = ~(NUM_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk_10Mhz or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      idx         <= '0;
      sh_seg      <= '1;
      sh_en       <= '0;
      sh_br       <= '1;
      ac_seg      <= '1;
      ac_en       <= '0;
      ac_br       <= '1;
      pending     <= 1'b0;
      seg         <= 8'hFF;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= wrap ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (load) begin
        sh_seg <= seg_data;
        sh_en  <= digit_en;
        sh_br  <= brightness;
      end

      // A load on the wrap tick bypasses the shadow so it shows at once.
      // It also supersedes anything already pending.
      if (wrap && load) begin
        ac_seg  <= seg_data;
        ac_en   <= digit_en;
        ac_br   <= brightness;
        pending <= 1'b0;
      end else if (wrap && pending) begin
        ac_seg  <= sh_seg;
        ac_en   <= sh_en;
        ac_br   <= sh_br;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      seg         <= seg_nxt;
      an          <= an_nxt;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_disp_scan_cntrl.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_cntrl
//   Directed bench for disp_scan_cntrl. It uses NUM_DIGITS=4 and DIV=32, so a
//   frame lasts 128 cycles. Each table record gives the digit data and the last
//   lit slot cycle, worked out by hand. Every cycle of a frame is compared with
//   the record that should be on display. Mid-frame loads must not show until
//   the following frame.
// -----------------------------------------------------------------------------
module tb_disp_scan_cntrl;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  en;
    logic [3:0]  br;
    int          hi;   // last lit cycle within a slot (first is always 2)
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] seg_data;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic        load;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[5];
  vec_t blank, none, va, vb, vc, prev;

  disp_scan_cntrl #(
    .NUM_DIGITS(4), .CLK_HZ(3200), .SCAN_HZ(100), .BRIGHT_W(4), .GUARD(2)
  ) dut (
    .clk_10Mhz  (clk),
    .reset      (rst_n),
    .seg_data   (seg_data),
    .digit_en   (digit_en),
    .brightness (brightness),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] ean,
                            input logic [7:0] eseg, input logic efs);
    n_checks++;
    if (an !== ean || seg !== eseg || frame_start !== efs) begin
      n_fail++;
      $display("FAIL %s: an=%h seg=%h fs=%b, required an=%h seg=%h fs=%b",
               name, an, seg, frame_start, ean, eseg, efs);
    end
  endtask

  // Offset k counts negedges after the frame_start sample. Outputs seen at
  // offset k come from the slot state of offset k-1.
  task automatic check_cycle(input vec_t v, input int k, input string tag);
    int         c, d;
    logic       lit;
    logic [3:0] ean;
    logic [7:0] eseg;
    string      nm;
    c    = (k - 1) % 32;
    d    = (k - 1) / 32;
    lit  = v.en[d] && (c >= 2) && (c <= v.hi);
    ean  = lit ? ~(4'b0001 << d) : 4'hF;
    eseg = lit ? v.data[8*d +: 8] : 8'hFF;
    nm   = $sformatf("%s k=%0d", tag, k);
    check_outs(nm, ean, eseg, (k == 128));
  endtask

  task automatic drive(input vec_t v);
    seg_data   = v.data;
    digit_en   = v.en;
    brightness = v.br;
    load       = 1'b1;
  endtask

  // Starts on a frame_start sample and ends on the next one.
  task automatic run_frame(input vec_t ex, input vec_t la, input int ka,
                           input vec_t lb, input int kb, input string tag);
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      load = 1'b0;
      check_cycle(ex, k, tag);
      if (k == ka) drive(la);
      if (k == kb) drive(lb);
    end
  endtask

  // Counts negedges from reset release to the first frame_start.
  // Outputs must stay blank throughout.
  task automatic first_frame(input string tag);
    int   n;
    logic blank_ok;
    n        = 0;
    blank_ok = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (frame_start) begin
        n = i;
        break;
      end
      if (an !== 4'hF || seg !== 8'hFF) blank_ok = 1'b0;
    end
    check_int({tag, " first_fs_latency"}, n, 128);
    check_bit({tag, " blank_before_fs"}, blank_ok, 1'b1);
  endtask

  initial begin
    vecs[0] = '{data: 32'hC0F9A4B0, en: 4'hF,    br: 4'hF, hi: 31};
    vecs[1] = '{data: 32'hC0F9A4B0, en: 4'hF,    br: 4'h3, hi: 7};
    vecs[2] = '{data: 32'hC0F9A4B0, en: 4'b1010, br: 4'hF, hi: 31};
    vecs[3] = '{data: 32'h92998286, en: 4'hF,    br: 4'h0, hi: 2};
    vecs[4] = '{data: 32'h12345678, en: 4'b0001, br: 4'h7, hi: 15};
    blank   = '{data: 32'hFFFFFFFF, en: 4'h0,    br: 4'hF, hi: 31};
    none    = blank;
    va      = '{data: 32'h11223344, en: 4'hF,    br: 4'hF, hi: 31};
    vb      = '{data: 32'h8899AABB, en: 4'b0110, br: 4'h7, hi: 15};
    vc      = '{data: 32'h55667788, en: 4'hF,    br: 4'h3, hi: 7};

    rst_n      = 1'b0;
    load       = 1'b0;
    seg_data   = '0;
    digit_en   = '0;
    brightness = '0;
    repeat (3) @(negedge clk);
    check_outs("reset_state", 4'hF, 8'hFF, 1'b0);
    rst_n = 1'b1;
    first_frame("post_reset");

    // Blank display after reset, then each table record in turn. Every record
    // is loaded mid-frame and must first appear in the following frame.
    prev = blank;
    for (int i = 0; i < 5; i++) begin
      run_frame(prev, vecs[i], 40, none, -1, $sformatf("vec%0d_load", i));
      prev = vecs[i];
    end
    run_frame(prev, none, -1, none, -1, "vec4_hold");

    // Two loads in one frame: only the second is shown.
    run_frame(prev, va, 20, vb, 90, "two_loads");
    run_frame(vb, none, -1, none, -1, "two_loads_show_b");

    // A load on the wrap-tick cycle is shown in the frame that starts at once.
    run_frame(vb, vc, 127, none, -1, "wrap_load");
    run_frame(vc, none, -1, none, -1, "wrap_load_show");

    // Assert reset asynchronously while digit 2 is lit.
    repeat (70) @(negedge clk);
    check_outs("digit2_lit_pre_reset", 4'hB, 8'h66, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_outs("async_reset_blank", 4'hF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    check_outs("held_reset_blank", 4'hF, 8'hFF, 1'b0);
    rst_n = 1'b1;
    first_frame("mid_reset");
    run_frame(blank, none, -1, none, -1, "after_reset_blank");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
